// File: rtl/commit_perf_monitor_if.sv
// commit_perf_monitor_if
// Groups the commit-stream taps and the monitor's result registers in one bundle.
//   master : the commit source. It drives valid/order/inst and reads the results.
//   slave  : the monitor. It samples valid/order/inst and drives the results.
// Signals:
//   valid       CHANNELS      per-lane commit valid
//   order       CHANNELSx64   per-lane commit order number
//   inst        CHANNELSx32   per-lane committed instruction
//   halt        1             sticky halt-committed flag
//   seg_state   2             0=IDLE, 1=SEG, 2=DONE
//   inst_count  CNT_W         committed instructions in the current window
//   cycle_count CNT_W         cycles in the current window
//   pwr_start_ts/pwr_stop_ts  CNT_W timestamps of the power markers
//   pwr_valid   1             sticky; power window closed
//   order_err   1             sticky ordering/packing error
//   err_lane    3             lowest offending lane of the first error
interface commit_perf_monitor_if #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 32
);
   logic [CHANNELS-1:0]        valid;
   logic [CHANNELS-1:0][63:0]  order;
   logic [CHANNELS-1:0][31:0]  inst;
   logic                       halt;
   logic [1:0]                 seg_state;
   logic [CNT_W-1:0]           inst_count;
   logic [CNT_W-1:0]           cycle_count;
   logic [CNT_W-1:0]           pwr_start_ts;
   logic [CNT_W-1:0]           pwr_stop_ts;
   logic                       pwr_valid;
   logic                       order_err;
   logic [2:0]                 err_lane;

   modport master (
      output valid, order, inst,
      input  halt, seg_state, inst_count, cycle_count,
             pwr_start_ts, pwr_stop_ts, pwr_valid, order_err, err_lane
   );

   modport slave (
      input  valid, order, inst,
      output halt, seg_state, inst_count, cycle_count,
             pwr_start_ts, pwr_stop_ts, pwr_valid, order_err, err_lane
   );
endinterface

// File: rtl/commit_perf_monitor.sv
// commit_perf_monitor
// Watches the ROB commit port. It checks commit ordering and lane packing, and
// detects halt instructions. It tracks segment and power-window markers and
// keeps saturating instruction and cycle counters. All results are registered.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   mon  commit_perf_monitor_if.slave. It carries the per-lane commit inputs
//        and the registered results.
module commit_perf_monitor #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 32
) (
   input logic                 clk,
   input logic                 rst,
   commit_perf_monitor_if.slave mon
);
   localparam logic [31:0] HALT_A    = 32'h0000_0063;
   localparam logic [31:0] HALT_B    = 32'h0000_006F;
   localparam logic [31:0] HALT_C    = 32'hF000_2013;
   localparam logic [31:0] SEG_START = 32'h0010_2013;
   localparam logic [31:0] SEG_STOP  = 32'h0020_2013;
   localparam logic [31:0] PWR_START = 32'h0030_2013;
   localparam logic [31:0] PWR_STOP  = 32'h0040_2013;

   typedef enum logic [1:0] {
      SEG_IDLE = 2'd0,
      SEG_RUN  = 2'd1,
      SEG_DONE = 2'd2
   } seg_t;

   seg_t             seg_reg, seg_next;
   logic             halt_reg, halt_next;
   logic [CNT_W-1:0] inst_cnt_reg, inst_cnt_next;
   logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
   logic [CNT_W-1:0] pwr_start_reg, pwr_start_next;
   logic [CNT_W-1:0] pwr_stop_reg, pwr_stop_next;
   logic             pwr_valid_reg, pwr_valid_next;
   logic             order_err_reg, order_err_next;
   logic [2:0]       err_lane_reg, err_lane_next;
   logic [CNT_W-1:0] ts_reg, ts_next;
   logic [63:0]      exp_order_reg, exp_order_next;
   logic             lanes_done;

   logic [CHANNELS-1:0] lane_halt, lane_seg_start, lane_seg_stop;
   logic [CHANNELS-1:0] lane_pwr_start, lane_pwr_stop;
   logic [CHANNELS-1:0] lane_order_ok, lane_hole;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Per-lane decode. A "hole" is a clear lane that has a set lane above it.
   // The hole itself is reported as the offending lane.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign lane_halt[gi]      = (mon.inst[gi] == HALT_A) || (mon.inst[gi] == HALT_B) ||
                                  (mon.inst[gi] == HALT_C);
      assign lane_seg_start[gi] = (mon.inst[gi] == SEG_START);
      assign lane_seg_stop[gi]  = (mon.inst[gi] == SEG_STOP);
      assign lane_pwr_start[gi] = (mon.inst[gi] == PWR_START);
      assign lane_pwr_stop[gi]  = (mon.inst[gi] == PWR_STOP);
      assign lane_order_ok[gi]  = (mon.order[gi] == exp_order_reg + 64'(gi));
      assign lane_hole[gi]      = !mon.valid[gi] && ((mon.valid >> (gi + 1)) != '0);
   end

   // Lanes are resolved in ascending order. Each lane sees the *_next values
   // left by the lanes below it.
   always_comb begin
      seg_next       = seg_reg;
      halt_next      = halt_reg;
      inst_cnt_next  = inst_cnt_reg;
      cyc_cnt_next   = cyc_cnt_reg;
      pwr_start_next = pwr_start_reg;
      pwr_stop_next  = pwr_stop_reg;
      pwr_valid_next = pwr_valid_reg;
      order_err_next = order_err_reg;
      err_lane_next  = err_lane_reg;
      exp_order_next = exp_order_reg;
      ts_next        = ts_reg + CNT_W'(1);
      lanes_done     = 1'b0;

      if (!halt_reg) begin
         // The cycle increment comes before the lanes are processed.
         // A SEG_START later in this cycle then clears it, so that cycle contributes 0.
         if (seg_reg != SEG_DONE) cyc_cnt_next = sat_inc(cyc_cnt_reg);

         for (int c = 0; c < CHANNELS; c++) begin
            if (!lanes_done) begin
               if (lane_hole[c] || (mon.valid[c] && !lane_order_ok[c])) begin
                  if (!order_err_next) begin
                     order_err_next = 1'b1;
                     err_lane_next  = 3'(c);
                  end
               end
               if (mon.valid[c]) begin
                  exp_order_next = mon.order[c] + 64'd1;
                  if (lane_seg_start[c]) begin
                     // The marker lane itself is not counted. Only lanes above it are.
                     seg_next      = SEG_RUN;
                     inst_cnt_next = '0;
                     cyc_cnt_next  = '0;
                  end else begin
                     if (seg_next != SEG_DONE) inst_cnt_next = sat_inc(inst_cnt_next);
                     if (lane_halt[c]) begin
                        halt_next  = 1'b1;
                        lanes_done = 1'b1;
                     end else if (lane_seg_stop[c] && (seg_next != SEG_DONE)) begin
                        // Lanes above this one fall into DONE and are no longer counted.
                        seg_next = SEG_DONE;
                        if (!pwr_valid_next) begin
                           pwr_stop_next  = ts_reg;
                           pwr_valid_next = 1'b1;
                        end
                     end else if (lane_pwr_start[c] && !pwr_valid_next) begin
                        pwr_start_next = ts_reg;
                     end else if (lane_pwr_stop[c] && !pwr_valid_next) begin
                        pwr_stop_next  = ts_reg;
                        pwr_valid_next = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_reg       <= SEG_IDLE;
         halt_reg      <= 1'b0;
         inst_cnt_reg  <= '0;
         cyc_cnt_reg   <= '0;
         pwr_start_reg <= '0;
         pwr_stop_reg  <= '0;
         pwr_valid_reg <= 1'b0;
         order_err_reg <= 1'b0;
         err_lane_reg  <= '0;
         ts_reg        <= '0;
         exp_order_reg <= '0;
      end else begin
         seg_reg       <= seg_next;
         halt_reg      <= halt_next;
         inst_cnt_reg  <= inst_cnt_next;
         cyc_cnt_reg   <= cyc_cnt_next;
         pwr_start_reg <= pwr_start_next;
         pwr_stop_reg  <= pwr_stop_next;
         pwr_valid_reg <= pwr_valid_next;
         order_err_reg <= order_err_next;
         err_lane_reg  <= err_lane_next;
         ts_reg        <= ts_next;
         exp_order_reg <= exp_order_next;
      end
   end

   assign mon.halt         = halt_reg;
   assign mon.seg_state    = seg_reg;
   assign mon.inst_count   = inst_cnt_reg;
   assign mon.cycle_count  = cyc_cnt_reg;
   assign mon.pwr_start_ts = pwr_start_reg;
   assign mon.pwr_stop_ts  = pwr_stop_reg;
   assign mon.pwr_valid    = pwr_valid_reg;
   assign mon.order_err    = order_err_reg;
   assign mon.err_lane     = err_lane_reg;
endmodule

// File: tb/tb_commit_perf_monitor.sv
// tb_commit_perf_monitor
// Directed bench for commit_perf_monitor.
//   dut_a : CHANNELS=2, CNT_W=32. Covers counting, segments, power markers,
//           halt and ordering.
//   dut_b : CHANNELS=2, CNT_W=4. Covers saturation, timestamp wrap and
//           asynchronous reset.
module tb_commit_perf_monitor;
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] HALT_JAL  = 32'h0000_006F;
   localparam logic [31:0] SEG_START = 32'h0010_2013;
   localparam logic [31:0] SEG_STOP  = 32'h0020_2013;
   localparam logic [31:0] PWR_START = 32'h0030_2013;
   localparam logic [31:0] PWR_STOP  = 32'h0040_2013;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   commit_perf_monitor_if #(.CHANNELS(2), .CNT_W(32)) ifa ();
   commit_perf_monitor_if #(.CHANNELS(2), .CNT_W(4))  ifb ();

   commit_perf_monitor #(.CHANNELS(2), .CNT_W(32)) dut_a (.clk(clk), .rst(rst_a), .mon(ifa.slave));
   commit_perf_monitor #(.CHANNELS(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst_b), .mon(ifb.slave));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one commit cycle, let one rising edge pass, and return 1 time unit after it.
   task automatic step_a(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic [31:0] i0, input logic [31:0] i1);
      ifa.valid = v; ifa.order[0] = o0; ifa.order[1] = o1; ifa.inst[0] = i0; ifa.inst[1] = i1;
      @(posedge clk); #1;
      $display("A: valid=%b o0=%0d o1=%0d i0=%h i1=%h -> inst=%0d cyc=%0d seg=%0d halt=%0b err=%0b",
               v, o0, o1, i0, i1, ifa.inst_count, ifa.cycle_count, ifa.seg_state, ifa.halt, ifa.order_err);
   endtask

   task automatic step_b(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                         input logic [31:0] i0, input logic [31:0] i1);
      ifb.valid = v; ifb.order[0] = o0; ifb.order[1] = o1; ifb.inst[0] = i0; ifb.inst[1] = i1;
      @(posedge clk); #1;
      $display("B: valid=%b o0=%0d o1=%0d i0=%h i1=%h -> inst=%0d cyc=%0d seg=%0d",
               v, o0, o1, i0, i1, ifb.inst_count, ifb.cycle_count, ifb.seg_state);
   endtask

   // Reset dut_a, then release it on a falling edge. The next step is then the
   // first edge with ts=0.
   task automatic reset_a();
      @(negedge clk);
      rst_a = 1'b1;
      ifa.valid = '0;
      @(negedge clk);
      rst_a = 1'b0;
   endtask

   initial begin
      ifa.valid = '0; ifa.order = '0; ifa.inst = '0;
      ifb.valid = '0; ifb.order = '0; ifb.inst = '0;

      // Reset state
      @(negedge clk);
      chk("rst_halt", 64'(ifa.halt), 64'd0);
      chk("rst_seg", 64'(ifa.seg_state), 64'd0);
      chk("rst_inst", 64'(ifa.inst_count), 64'd0);
      chk("rst_cyc", 64'(ifa.cycle_count), 64'd0);
      chk("rst_err", 64'(ifa.order_err), 64'd0);
      chk("rst_pwrv", 64'(ifa.pwr_valid), 64'd0);

      // Phase 1: plain counting, then a segment
      reset_a();
      for (int k = 0; k < 10; k++) step_a(2'b11, 64'(2 * k), 64'(2 * k + 1), NOP, NOP);
      chk("p1_inst", 64'(ifa.inst_count), 64'd20);
      chk("p1_cyc", 64'(ifa.cycle_count), 64'd10);
      chk("p1_err", 64'(ifa.order_err), 64'd0);
      chk("p1_seg", 64'(ifa.seg_state), 64'd0);

      step_a(2'b11, 64'd20, 64'd21, SEG_START, NOP);
      chk("segstart_seg", 64'(ifa.seg_state), 64'd1);
      chk("segstart_inst", 64'(ifa.inst_count), 64'd1);
      chk("segstart_cyc", 64'(ifa.cycle_count), 64'd0);

      for (int k = 0; k < 4; k++) step_a(2'b01, 64'(22 + k), 64'd0, NOP, NOP);
      chk("seg_mid_inst", 64'(ifa.inst_count), 64'd5);
      chk("seg_mid_cyc", 64'(ifa.cycle_count), 64'd4);

      step_a(2'b01, 64'd26, 64'd0, SEG_STOP, NOP);      // ts = 15
      chk("segstop_seg", 64'(ifa.seg_state), 64'd2);
      chk("segstop_inst", 64'(ifa.inst_count), 64'd6);
      chk("segstop_cyc", 64'(ifa.cycle_count), 64'd5);
      chk("segstop_pwrv", 64'(ifa.pwr_valid), 64'd1);
      chk("segstop_pwrts", 64'(ifa.pwr_stop_ts), 64'd15);

      step_a(2'b11, 64'd27, 64'd28, NOP, NOP);
      step_a(2'b11, 64'd29, 64'd30, SEG_STOP, NOP);
      chk("done_inst", 64'(ifa.inst_count), 64'd6);
      chk("done_cyc", 64'(ifa.cycle_count), 64'd5);
      chk("done_seg", 64'(ifa.seg_state), 64'd2);
      chk("done_err", 64'(ifa.order_err), 64'd0);

      // Phase 2: power markers, then halt
      reset_a();
      for (int k = 0; k < 5; k++) step_a(2'b00, 64'd0, 64'd0, NOP, NOP);
      step_a(2'b01, 64'd0, 64'd0, PWR_START, NOP);      // ts = 5
      for (int k = 0; k < 6; k++) step_a(2'b00, 64'd0, 64'd0, NOP, NOP);
      step_a(2'b01, 64'd1, 64'd0, PWR_STOP, NOP);       // ts = 12
      chk("pwr_start", 64'(ifa.pwr_start_ts), 64'd5);
      chk("pwr_stop", 64'(ifa.pwr_stop_ts), 64'd12);
      chk("pwr_valid", 64'(ifa.pwr_valid), 64'd1);
      chk("pwr_inst", 64'(ifa.inst_count), 64'd2);
      chk("pwr_cyc", 64'(ifa.cycle_count), 64'd13);
      for (int k = 0; k < 7; k++) step_a(2'b00, 64'd0, 64'd0, NOP, NOP);
      step_a(2'b01, 64'd2, 64'd0, PWR_STOP, NOP);       // ts = 20, ignored
      step_a(2'b01, 64'd3, 64'd0, PWR_START, NOP);      // ts = 21, ignored
      chk("pwr2_start", 64'(ifa.pwr_start_ts), 64'd5);
      chk("pwr2_stop", 64'(ifa.pwr_stop_ts), 64'd12);
      chk("pwr2_inst", 64'(ifa.inst_count), 64'd4);

      step_a(2'b11, 64'd4, 64'd5, HALT_JAL, NOP);
      chk("halt_set", 64'(ifa.halt), 64'd1);
      chk("halt_inst", 64'(ifa.inst_count), 64'd5);
      chk("halt_cyc", 64'(ifa.cycle_count), 64'd23);
      step_a(2'b11, 64'd6, 64'd7, SEG_START, NOP);
      step_a(2'b10, 64'd0, 64'd0, NOP, NOP);
      chk("post_halt_inst", 64'(ifa.inst_count), 64'd5);
      chk("post_halt_cyc", 64'(ifa.cycle_count), 64'd23);
      chk("post_halt_seg", 64'(ifa.seg_state), 64'd0);
      chk("post_halt_err", 64'(ifa.order_err), 64'd0);

      // Phase 3: ordering errors
      reset_a();
      step_a(2'b10, 64'd0, 64'd1, NOP, NOP);
      chk("hole_err", 64'(ifa.order_err), 64'd1);
      chk("hole_lane", 64'(ifa.err_lane), 64'd0);
      step_a(2'b11, 64'd2, 64'd4, NOP, NOP);
      chk("hole_lane_kept", 64'(ifa.err_lane), 64'd0);

      reset_a();
      step_a(2'b01, 64'd0, 64'd0, NOP, NOP);
      chk("ord_ok_err", 64'(ifa.order_err), 64'd0);
      step_a(2'b11, 64'd1, 64'd3, NOP, NOP);
      chk("skip_err", 64'(ifa.order_err), 64'd1);
      chk("skip_lane", 64'(ifa.err_lane), 64'd1);

      // Phase 4: narrow counters on dut_b
      @(negedge clk);
      rst_b = 1'b0;
      for (int k = 0; k < 17; k++) step_b(2'b11, 64'(2 * k), 64'(2 * k + 1), NOP, NOP);
      chk("sat_inst", 64'(ifb.inst_count), 64'd15);
      chk("sat_cyc", 64'(ifb.cycle_count), 64'd15);
      chk("sat_err", 64'(ifb.order_err), 64'd0);
      step_b(2'b11, 64'd34, 64'd35, SEG_START, PWR_START);  // ts = 17 mod 16 = 1
      chk("b_seg", 64'(ifb.seg_state), 64'd1);
      chk("b_inst", 64'(ifb.inst_count), 64'd1);
      chk("b_cyc", 64'(ifb.cycle_count), 64'd0);
      chk("b_ts_wrap", 64'(ifb.pwr_start_ts), 64'd1);

      // Assert reset between edges; the outputs must clear before the next edge.
      #2 rst_b = 1'b1;
      #1;
      chk("arst_halt", 64'(ifb.halt), 64'd0);
      chk("arst_seg", 64'(ifb.seg_state), 64'd0);
      chk("arst_inst", 64'(ifb.inst_count), 64'd0);
      chk("arst_cyc", 64'(ifb.cycle_count), 64'd0);
      chk("arst_pstart", 64'(ifb.pwr_start_ts), 64'd0);
      chk("arst_pstop", 64'(ifb.pwr_stop_ts), 64'd0);
      chk("arst_pvalid", 64'(ifb.pwr_valid), 64'd0);
      chk("arst_err", 64'(ifb.order_err), 64'd0);
      chk("arst_lane", 64'(ifb.err_lane), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/commit_perf_monitor.md
# commit_perf_monitor

Synthesizable, multi-channel commit-stream monitor that sits beside the ROB commit port, in parallel with the RVFI taps. It checks commit ordering across up to CHANNELS retire lanes and detects halt instructions. It runs segment and power-window marker state and keeps saturating instruction and cycle counters, so IPC and power windows can be read on silicon/FPGA without simulation-only code.

## Interface
- CHANNELS, 2, number of commit lanes per cycle (1..8)
- CNT_W, 32, width of instruction/cycle counters and timestamps
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- valid  in  CHANNELS  per-lane commit valid
- order  in  CHANNELS x 64  per-lane commit order number
- inst  in  CHANNELS x 32  per-lane committed instruction
- halt  out  1  sticky; a halt instruction has committed
- seg_state  out  2  0=IDLE, 1=SEG, 2=DONE
- inst_count  out  CNT_W  committed instructions in current window
- cycle_count  out  CNT_W  cycles in current window
- pwr_start_ts  out  CNT_W  timestamp of last power-start marker
- pwr_stop_ts  out  CNT_W  timestamp of power-stop marker
- pwr_valid  out  1  sticky; power window closed
- order_err  out  1  sticky ordering/packing error
- err_lane  out  3  lowest offending lane of first error

## Operation
- Halt instructions: 0x00000063, 0x0000006F, 0xF0002013.
- Markers:
  - SEG_START 0x00102013
  - SEG_STOP 0x00202013
  - PWR_START 0x00302013
  - PWR_STOP 0x00402013
- Lanes are processed in ascending index within a cycle. Later lanes see the effects of earlier lanes.
- Halt:
  - The first valid lane carrying a halt instruction sets halt.
  - That lane is counted. Higher lanes in the same cycle are ignored entirely.
  - Once halt=1, all counting, markers and order checks stop.
- Timestamp: internal free-running CNT_W counter `ts`, +1 every cycle, wraps at 2^CNT_W. Markers capture the pre-increment value.
- Counters:
  - cycle_count +1 per cycle in IDLE and SEG.
  - inst_count +1 per counted valid lane in IDLE and SEG.
  - Both saturate at all-ones and freeze in DONE.
- SEG_START, from any state:
  - Enter SEG.
  - inst_count resets to the number of counted lanes above the marker lane in that cycle.
  - cycle_count resets to 0 (that cycle contributes 0).
- SEG_STOP in IDLE or SEG: counted (inst_count includes it), then enter DONE.
  - Lanes above it in the same cycle are not counted.
  - SEG_STOP in DONE is ignored.
- PWR_START: pwr_start_ts <= ts. Allowed repeatedly until pwr_valid.
- PWR_STOP:
  - If pwr_valid=0: pwr_stop_ts <= ts, pwr_valid <= 1.
  - The first SEG_STOP with pwr_valid=0 does the same.
- Order check, with internal `exp_order` (64 bit, reset 0):
  - Valid must be packed: no set bit above a clear bit.
  - Valid lane c must have order == exp_order + c.
  - On any violation: order_err <= 1. err_lane captures the lowest violating lane on the first error only.
  - exp_order <= order[highest valid lane] + 1 whenever any lane is valid. This resyncs the check and avoids error cascades.

## Timing
- All outputs registered. The effect of a commit in cycle N is visible after the clk edge ending cycle N.
- Reset (async assert, sync-released on clk):
  - All outputs = 0, seg_state = IDLE.
  - ts = 0, exp_order = 0.
  - Reset mid-segment discards all state.
- No handshake; inputs are sampled every cycle. No backpressure.
- All markers and a halt in one cycle are resolved in lane order within that single cycle.
- Counter saturation: a counter at all-ones stays all-ones; no wrap.
- ts wrap: pwr_stop_ts may be < pwr_start_ts. Consumers compute the difference modulo 2^CNT_W.

## Test plan
- Reset, then 10 cycles with valid=2'b11 and orders 0..19, non-marker inst → inst_count=20, cycle_count=10, order_err=0, seg_state=0.
- Cycle 3: lane0=SEG_START, lane1=nop. Cycles 4..7: valid=2'b01. Cycle 8: lane0=SEG_STOP.
  - Required: seg_state=1 after cycle 3 with inst_count=1, cycle_count=0.
  - After cycle 8: seg_state=2, inst_count=6, cycle_count=5, frozen afterwards.
- Cycle with lane0=0x0000006F, lane1 valid with order+1 → halt=1, inst_count +1 only; later commits change nothing.
- valid=2'b10 → order_err=1, err_lane=0. Order skip on lane1 (exp+2) with packed valid → err_lane=1 only if no prior error.
- PWR_START at ts=5, PWR_STOP at ts=12, second PWR_STOP at ts=20 → pwr_start_ts=5, pwr_stop_ts=12, pwr_valid=1.
- CNT_W=4: 20 commits → inst_count=15 (saturated). Assert rst mid-segment → every output 0 immediately, without waiting for clk.
